// File: rtl/vpu_afifo_pkg.sv
// Shared constants for the VPU aFifo read-side datapath.
package vpu_afifo_pkg;

    localparam int VPU_FIFO_DATA_WIDTH = 80;
    localparam int VPU_BEAT_WIDTH      = 16;
    localparam int VPU_FIFO_BEATS      = VPU_FIFO_DATA_WIDTH / VPU_BEAT_WIDTH;

    // Beat counter width; never narrower than one bit, even for a single-beat word.
    function automatic int beat_idx_width(input int beats);
        return (beats > 1) ? $clog2(beats) : 1;
    endfunction

    localparam int VPU_BEAT_IDX_WIDTH = beat_idx_width(VPU_FIFO_BEATS);

endpackage

// File: rtl/afifo_rd_wordbuf.sv
// Two-entry word buffer behind the aFifo read port; push and pop may coincide.
module afifo_rd_wordbuf
    import vpu_afifo_pkg::*;
#(
    parameter int WIDTH = VPU_FIFO_DATA_WIDTH
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] mem [2];
    logic             wr_ptr;
    logic             rd_ptr;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else if (clear) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: ;
            endcase
        end
    end

    assign head_data = mem[rd_ptr];

    // Read-enable gating upstream keeps a capture from ever landing on a full buffer.
    assert property (@(posedge Clk) disable iff (!Rst_n) !(push && !clear && count == 2'd2));

endmodule

// File: rtl/afifo_rd_unpack.sv
// aFifo read-side consumer: pops words, absorbs the registered read latency, emits LSB-first beats.
module afifo_rd_unpack
    import vpu_afifo_pkg::*;
#(
    parameter int DATA_WIDTH = VPU_FIFO_DATA_WIDTH,
    parameter int OUT_WIDTH  = VPU_BEAT_WIDTH
) (
    input  logic                  Clk,
    input  logic                  Rst_n,
    input  logic                  Clear_in,
    input  logic                  Fifo_Empty_in,
    output logic                  Fifo_ReadEn_out,
    input  logic [DATA_WIDTH-1:0] Fifo_Data_in,
    output logic [OUT_WIDTH-1:0]  Out_Data,
    output logic                  Out_Valid,
    output logic                  Out_Last,
    input  logic                  Out_Ready,
    output logic                  Busy_out
);

    localparam int BEATS     = DATA_WIDTH / OUT_WIDTH;
    localparam int BUF_WORDS = 2;
    localparam int IDX_W     = beat_idx_width(BEATS);

    generate
        if (DATA_WIDTH % OUT_WIDTH != 0) begin : g_bad_width
            $error("afifo_rd_unpack: DATA_WIDTH must be a multiple of OUT_WIDTH");
        end
    endgenerate

    logic                  inflight;
    logic [IDX_W-1:0]      beat;
    logic [1:0]            count;
    logic [DATA_WIDTH-1:0] head;
    logic [2:0]            occ;
    logic                  pop_accept;
    logic                  last_beat;
    logic                  handshake;
    logic                  drop;

    // Words in flight count against the buffer so a captured word always has a slot.
    assign occ             = {1'b0, count} + {2'b00, inflight};
    assign Fifo_ReadEn_out = Rst_n & ~Clear_in & (occ < 3'(BUF_WORDS));
    assign pop_accept      = Fifo_ReadEn_out & ~Fifo_Empty_in;

    assign last_beat = (beat == IDX_W'(BEATS - 1));
    assign handshake = Out_Valid & Out_Ready;
    assign drop      = handshake & last_beat;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            inflight <= 1'b0;
            beat     <= '0;
        end else if (Clear_in) begin
            inflight <= 1'b0;
            beat     <= '0;
        end else begin
            inflight <= pop_accept;
            if (handshake) begin
                beat <= last_beat ? '0 : beat + IDX_W'(1);
            end
        end
    end

    afifo_rd_wordbuf #(
        .WIDTH (DATA_WIDTH)
    ) u_wordbuf (
        .Clk       (Clk),
        .Rst_n     (Rst_n),
        .clear     (Clear_in),
        .push      (inflight),
        .push_data (Fifo_Data_in),
        .pop       (drop),
        .head_data (head),
        .count     (count)
    );

    assign Out_Valid = (count != 2'd0);
    assign Out_Last  = Out_Valid & last_beat;
    assign Out_Data  = Out_Valid ? head[int'(beat) * OUT_WIDTH +: OUT_WIDTH] : '0;
    assign Busy_out  = (occ != 3'd0);

endmodule

// File: tb/tb_afifo_rd_unpack.sv
// Bench for afifo_rd_unpack: aFifo source model, beat-stream scoreboard, table and corner sequences.
module tb_afifo_rd_unpack;

    localparam int BEATS = 5;

    logic        Clk = 1'b0;
    logic        Rst_n = 1'b0;
    logic        Clear_in = 1'b0;
    logic        Fifo_Empty_in;
    logic        Fifo_ReadEn_out;
    logic [79:0] Fifo_Data_in = '0;
    logic [15:0] Out_Data;
    logic        Out_Valid;
    logic        Out_Last;
    logic        Out_Ready = 1'b0;
    logic        Busy_out;

    int n_tests = 0;
    int n_fail  = 0;

    logic [79:0] mem [128];
    int          wr_idx = 0;
    int          rd_idx = 0;
    logic        hold_empty = 1'b0;

    int          exp_w = 0;
    int          exp_b = 0;
    logic [79:0] mon_w;
    logic        held = 1'b0;
    logic [15:0] hold_d = '0;
    logic        hold_l = 1'b0;

    afifo_rd_unpack dut (
        .Clk             (Clk),
        .Rst_n           (Rst_n),
        .Clear_in        (Clear_in),
        .Fifo_Empty_in   (Fifo_Empty_in),
        .Fifo_ReadEn_out (Fifo_ReadEn_out),
        .Fifo_Data_in    (Fifo_Data_in),
        .Out_Data        (Out_Data),
        .Out_Valid       (Out_Valid),
        .Out_Last        (Out_Last),
        .Out_Ready       (Out_Ready),
        .Busy_out        (Busy_out)
    );

    always #5 Clk = ~Clk;

    // aFifo model: registered read data, flushed by its own reset and Clear_in.
    assign Fifo_Empty_in = hold_empty | (rd_idx == wr_idx);

    always @(posedge Clk) begin
        if (!Rst_n || Clear_in) begin
            rd_idx <= wr_idx;
        end else if (Fifo_ReadEn_out && !Fifo_Empty_in) begin
            Fifo_Data_in <= mem[rd_idx];
            rd_idx       <= rd_idx + 1;
        end
    end

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic put_word(input logic [79:0] w);
        mem[wr_idx] = w;
        wr_idx++;
    endtask

    // Scoreboard: every word written to the source, in order, split LSB-first.
    always @(negedge Clk) begin
        if (!Rst_n || Clear_in) begin
            if (Rst_n) chk("ren_during_clear", {79'd0, Fifo_ReadEn_out}, 80'd0);
            exp_w = wr_idx;
            exp_b = 0;
            held  = 1'b0;
        end else begin
            if (held) begin
                chk("hold_data", {64'd0, Out_Data}, {64'd0, hold_d});
                chk("hold_last", {79'd0, Out_Last}, {79'd0, hold_l});
            end
            if (!Out_Valid) chk("idle_outputs_zero", {63'd0, Out_Data, Out_Last}, 80'd0);
            if (Out_Valid && Out_Ready) begin
                mon_w = mem[exp_w];
                chk("beat_data", {64'd0, Out_Data}, {64'd0, mon_w[exp_b*16 +: 16]});
                chk("beat_last", {79'd0, Out_Last}, {79'd0, (exp_b == BEATS - 1)});
                exp_b++;
                if (exp_b == BEATS) begin
                    exp_b = 0;
                    exp_w++;
                end
            end
            held   = Out_Valid && !Out_Ready;
            hold_d = Out_Data;
            hold_l = Out_Last;
        end
    end

    task automatic drain(input string name);
        Out_Ready  = 1'b1;
        hold_empty = 1'b0;
        for (int g = 0; g < 300 && (Busy_out || rd_idx != wr_idx); g++) tick();
        chk({name, "_drained"}, {79'd0, Busy_out}, 80'd0);
        chk({name, "_all_beats"}, 80'(exp_w), 80'(wr_idx));
    endtask

    task automatic wait_beat(input string name, input logic [15:0] d);
        int g;
        g = 0;
        while (!(Out_Valid && Out_Data == d) && g < 100) begin
            tick();
            g++;
        end
        chk({name, "_reached"}, {79'd0, (g < 100)}, 80'd1);
    endtask

    typedef struct {
        logic        rdy;
        logic        ren;
        logic        vld;
        logic [15:0] data;
        logic        last;
        logic        busy;
    } vec_t;

    vec_t tbl [10];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [79:0] w;
        logic [31:0] r0, r1, r2;
        int          cnt;

        tbl[0] = '{1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1};
        tbl[2] = '{1'b1, 1'b1, 1'b1, 16'h0000, 1'b0, 1'b1};
        tbl[3] = '{1'b1, 1'b1, 1'b1, 16'h0001, 1'b0, 1'b1};
        tbl[4] = '{1'b0, 1'b1, 1'b1, 16'h0002, 1'b0, 1'b1};
        tbl[5] = '{1'b0, 1'b1, 1'b1, 16'h0002, 1'b0, 1'b1};
        tbl[6] = '{1'b1, 1'b1, 1'b1, 16'h0002, 1'b0, 1'b1};
        tbl[7] = '{1'b1, 1'b1, 1'b1, 16'h0003, 1'b0, 1'b1};
        tbl[8] = '{1'b1, 1'b1, 1'b1, 16'h0004, 1'b1, 1'b1};
        tbl[9] = '{1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0};

        repeat (3) tick();
        chk("rst_outputs", {76'd0, Out_Valid, Out_Last, Busy_out, Fifo_ReadEn_out}, 80'd0);
        chk("rst_data", {64'd0, Out_Data}, 80'd0);
        Rst_n = 1'b1;
        tick();

        // Single word, cycle by cycle, with a two-cycle stall on beat 2.
        put_word(80'h0004_0003_0002_0001_0000);
        for (int i = 0; i < 10; i++) begin
            Out_Ready = tbl[i].rdy;
            @(negedge Clk);
            chk($sformatf("tbl%0d_ren", i), {79'd0, Fifo_ReadEn_out}, {79'd0, tbl[i].ren});
            chk($sformatf("tbl%0d_valid", i), {79'd0, Out_Valid}, {79'd0, tbl[i].vld});
            chk($sformatf("tbl%0d_data", i), {64'd0, Out_Data}, {64'd0, tbl[i].data});
            chk($sformatf("tbl%0d_last", i), {79'd0, Out_Last}, {79'd0, tbl[i].last});
            chk($sformatf("tbl%0d_busy", i), {79'd0, Busy_out}, {79'd0, tbl[i].busy});
            tick();
        end

        // Streaming four words: no bubble once the first beat appears.
        Out_Ready = 1'b1;
        for (int i = 0; i < 4; i++) put_word({16'h1000 + 16'(i), 16'h2000, 16'h3000, 16'h4000, 16'h5000 + 16'(i)});
        for (int g = 0; g < 20 && !Out_Valid; g++) tick();
        cnt = 0;
        r0 = 0;
        for (int i = 0; i < 20; i++) begin
            if (!Out_Valid) cnt++;
            if (Out_Last) r0++;
            tick();
        end
        chk("stream_bubbles", 80'(cnt), 80'd0);
        chk("stream_lasts", 80'(r0), 80'd4);
        chk("stream_end_valid", {79'd0, Out_Valid}, 80'd0);
        drain("stream");

        // Backpressure on beat 2 for ten cycles.
        put_word(80'hA004_A003_A002_A001_A000);
        put_word(80'hB004_B003_B002_B001_B000);
        put_word(80'hC004_C003_C002_C001_C000);
        wait_beat("bp", 16'hA002);
        Out_Ready = 1'b0;
        repeat (10) tick();
        chk("bp_ren_low", {79'd0, Fifo_ReadEn_out}, 80'd0);
        chk("bp_hold_data", {64'd0, Out_Data}, 80'hA002);
        chk("bp_busy", {79'd0, Busy_out}, 80'd1);
        drain("bp");

        // Empty source: no pop, then first beat two edges after Empty falls.
        hold_empty = 1'b1;
        put_word(80'hE004_E003_E002_E001_E000);
        repeat (5) tick();
        chk("empty_idle", {77'd0, Out_Valid, Busy_out, Fifo_ReadEn_out}, 80'd1);
        hold_empty = 1'b0;
        tick();
        chk("empty_edge1", {78'd0, Out_Valid, Busy_out}, 80'd1);
        tick();
        chk("empty_edge2_valid", {79'd0, Out_Valid}, 80'd1);
        chk("empty_edge2_data", {64'd0, Out_Data}, 80'hE000);
        drain("empty");

        // Clear while one word is on beat 3 and the next is in flight.
        put_word(80'hD004_D003_D002_D001_D000);
        wait_beat("clr", 16'hD002);
        put_word(80'hF004_F003_F002_F001_F000);
        tick();
        chk("clr_setup_beat3", {64'd0, Out_Data}, 80'hD003);
        Out_Ready = 1'b0;
        Clear_in  = 1'b1;
        tick();
        Clear_in = 1'b0;
        chk("clr_after", {78'd0, Out_Valid, Busy_out}, 80'd0);
        Out_Ready = 1'b1;
        cnt = 0;
        repeat (3) begin
            if (Out_Valid) cnt++;
            tick();
        end
        chk("clr_no_beats", 80'(cnt), 80'd0);
        put_word(80'h9004_9003_9002_9001_9000);
        for (int g = 0; g < 20 && !Out_Valid; g++) tick();
        chk("clr_next_beat0", {64'd0, Out_Data}, 80'h9000);
        drain("clr");

        // Asynchronous reset in the middle of a word.
        put_word(80'h8004_8003_8002_8001_8000);
        wait_beat("arst", 16'h8001);
        #3;
        Rst_n = 1'b0;
        #1;
        chk("arst_outputs", {76'd0, Out_Valid, Out_Last, Busy_out, Fifo_ReadEn_out}, 80'd0);
        chk("arst_data", {64'd0, Out_Data}, 80'd0);
        hold_empty = 1'b1;
        repeat (2) @(posedge Clk);
        #1;
        Rst_n = 1'b1;
        cnt = 0;
        repeat (3) begin
            if (Busy_out || Out_Valid) cnt++;
            tick();
        end
        chk("arst_no_pop_while_empty", 80'(cnt), 80'd0);
        put_word(80'h7004_7003_7002_7001_7000);
        hold_empty = 1'b0;
        for (int g = 0; g < 20 && !Out_Valid; g++) tick();
        chk("arst_first_beat", {64'd0, Out_Data}, 80'h7000);
        drain("arst");

        // Random traffic, random backpressure and source stalls.
        cnt = 0;
        for (int c = 0; c < 400; c++) begin
            if (cnt < 40 && $urandom_range(0, 2) == 0) begin
                r0 = $urandom;
                r1 = $urandom;
                r2 = $urandom;
                w = {r2[15:0], r1, r0};
                put_word(w);
                cnt++;
            end
            Out_Ready  = ($urandom_range(0, 3) != 0);
            hold_empty = ($urandom_range(0, 4) == 0);
            tick();
        end
        drain("rand");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
